// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel: one request beat, one read beat.
interface fetch_if #(
  parameter int N = 32
) ();

  logic         req;
  logic [N-1:0] addr;
  logic         gnt;
  logic         rvalid;
  logic [31:0]  rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter: a redirect load wins over the sequential increment.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         load,
  input  logic         inc,
  input  logic [n-1:0] target,
  output logic [n-1:0] pc
);

  // Redirect targets are word-aligned by clearing the low two bits.
  logic [n-1:0] target_aligned;
  assign target_aligned = target & ~n'(3);

  // PC update; increment wraps naturally at 2^n.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target_aligned;
    end else if (inc) begin
      pc <= pc + n'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with a single outstanding imem transaction.
//
// state | meaning
// IDLE  | first cycle after reset release; late responses are ignored
// REQ   | request driven at pc, waiting for grant
// WAIT  | request granted, waiting for read data
// HOLD  | instruction captured while decode stalled; no new request
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0,
  parameter logic [31:0]  NOP      = NOP_INSTR
) (
  input  logic         clock,
  input  logic         nReset,
  input  logic         brnch,
  input  logic         is_branch,
  input  logic         jump,
  input  logic [n-1:0] target,
  input  logic         stall,
  fetch_if.master      imem,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [n-1:0] if_pc,
  output logic         flush
);

  fetch_state_t state, state_nxt;
  logic         stale;
  logic         redirect;
  logic         live_redirect;
  logic         pc_load;
  logic         pc_inc;
  logic         capture;
  logic         stale_set;
  logic         stale_clr;
  logic [n-1:0] pc;

  assign redirect      = jump | (is_branch & brnch);
  assign live_redirect = redirect && (state != IDLE);
  assign flush         = redirect & nReset;

  assign imem.req  = (state == REQ);
  assign imem.addr = pc;

  pc_reg #(
    .n        (n),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clock  (clock),
    .nReset (nReset),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (target),
    .pc     (pc)
  );

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-cycle control; redirect outranks stall and capture.
  always_comb begin
    state_nxt = state;
    pc_load   = live_redirect;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    stale_set = 1'b0;
    stale_clr = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = REQ;
      end
      REQ: begin
        if (imem.gnt) begin
          state_nxt = WAIT;
          // The granted address is now wrong-path; its data must be dropped.
          stale_set = redirect;
        end
      end
      WAIT: begin
        if (imem.rvalid) begin
          stale_clr = 1'b1;
          if (!stale && !redirect) begin
            capture   = 1'b1;
            pc_inc    = 1'b1;
            state_nxt = stall ? HOLD : REQ;
          end else begin
            state_nxt = REQ;
          end
        end else begin
          stale_set = redirect;
        end
      end
      HOLD: begin
        if (redirect || !stall) begin
          state_nxt = REQ;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Decode-facing output register and the wrong-path marker.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      stale    <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= NOP;
      if_pc    <= '0;
    end else begin
      if (stale_set) begin
        stale <= 1'b1;
      end else if (stale_clr) begin
        stale <= 1'b0;
      end
      if (live_redirect) begin
        if_valid <= 1'b0;
        if_instr <= NOP;
      end else if (capture) begin
        if_valid <= 1'b1;
        if_instr <= imem.rdata;
        if_pc    <= pc;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then random traffic
// against a transaction-level model of the fetch stream.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        nReset;
  logic        brnch;
  logic        is_branch;
  logic        jump;
  logic [31:0] target;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;

  fetch_if #(.N(32)) imem ();

  fetch_unit #(
    .n        (32),
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0013)
  ) dut (
    .clock     (clock),
    .nReset    (nReset),
    .brnch     (brnch),
    .is_branch (is_branch),
    .jump      (jump),
    .target    (target),
    .stall     (stall),
    .imem      (imem),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc     (if_pc),
    .flush     (flush)
  );

  initial forever #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: expected decode-side register contents, next expected
  // request address, and the single outstanding memory transaction.
  logic        m_v;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [31:0] exp_addr;
  logic [31:0] oaddr;
  bit          ob;
  bit          olive;
  bit          held;
  int          lat;
  int          lat_mode;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, check the
  // combinational view, advance the model, then compare registered outputs
  // at the next falling edge.
  task automatic cycle(input bit g, input bit st, input bit j, input bit ib,
                       input bit br, input logic [31:0] tg);
    bit redir;
    bit cap;
    bit gn;
    stall       = st;
    jump        = j;
    is_branch   = ib;
    brnch       = br;
    target      = tg;
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom;
    if (ob) begin
      if (lat == 0) begin
        imem.rvalid = 1'b1;
        imem.rdata  = mem_word(oaddr);
      end else begin
        lat--;
      end
    end
    gn       = g && (imem.req === 1'b1);
    imem.gnt = gn;
    #1;
    redir = j | (ib & br);
    chk("flush", flush, redir);
    if (ob) chk("one_outstanding", imem.req, 1'b0);
    if (held) chk("hold_no_req", imem.req, 1'b0);
    cap = imem.rvalid && ob && olive && !redir;
    if (imem.rvalid) ob = 1'b0;
    if (gn) begin
      chk("req_addr", imem.addr, exp_addr);
      ob       = 1'b1;
      oaddr    = exp_addr;
      olive    = !redir;
      lat      = (lat_mode < 0) ? int'($urandom_range(2, 0)) : lat_mode;
      exp_addr = exp_addr + 32'd4;
    end
    if (redir) begin
      olive    = 1'b0;
      exp_addr = tg & ~32'h3;
      m_v      = 1'b0;
      m_instr  = 32'h0000_0013;
      held     = 1'b0;
    end else if (cap) begin
      m_v     = 1'b1;
      m_instr = mem_word(oaddr);
      m_pc    = oaddr;
      held    = st;
    end else if (!st) begin
      m_v  = 1'b0;
      held = 1'b0;
    end
    @(negedge clock);
    chk("if_valid", if_valid, m_v);
    chk("if_instr", if_instr, m_instr);
    if (m_v) chk("if_pc", if_pc, m_pc);
  endtask

  // Asynchronous reset pulse starting mid-cycle; optionally leaves a response
  // in flight that will arrive in the first cycle after release.
  task automatic do_reset(input bit leftover);
    nReset      = 1'b0;
    jump        = 1'b1;
    is_branch   = 1'b0;
    brnch       = 1'b0;
    stall       = 1'b0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    #1;
    chk("rst_req", imem.req, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 32'h0000_0013);
    chk("rst_pc", if_pc, 32'h0);
    jump = 1'b0;
    @(negedge clock);
    @(negedge clock);
    nReset   = 1'b1;
    m_v      = 1'b0;
    m_instr  = 32'h0000_0013;
    m_pc     = 32'h0;
    exp_addr = 32'h0;
    held     = 1'b0;
    ob       = leftover;
    olive    = 1'b0;
    lat      = 0;
  endtask

  initial begin
    nReset      = 1'b0;
    brnch       = 1'b0;
    is_branch   = 1'b0;
    jump        = 1'b0;
    target      = 32'h0;
    stall       = 1'b0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    lat_mode    = 0;
    @(negedge clock);
    do_reset(1'b0);

    // First fetch from the reset PC, data one cycle after grant.
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0);
    chk("t1_valid", if_valid, 1'b1);
    chk("t1_instr", if_instr, 32'h0050_0093);
    chk("t1_pc", if_pc, 32'h0);
    chk("t1_req", imem.req, 1'b1);
    chk("t1_next_addr", imem.addr, 32'h4);

    // Taken branch while waiting: response dropped, refetch at target.
    lat_mode = 2;
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 1, 1, 32'h100);
    cycle(0, 0, 0, 0, 0, 32'h0);
    cycle(0, 0, 0, 0, 0, 32'h0);
    chk("t2_dropped", if_valid, 1'b0);
    chk("t2_req", imem.req, 1'b1);
    chk("t2_addr", imem.addr, 32'h100);

    // Not-taken branch: sequential fetch continues.
    lat_mode = 0;
    repeat (6) cycle(1, 0, 0, 1, 0, 32'h40);
    chk("t3_pc", if_pc, 32'h108);

    // Stall: output held, no requests until stall drops.
    cycle(1, 1, 0, 0, 0, 32'h0);
    cycle(1, 1, 0, 0, 0, 32'h0);
    repeat (8) cycle(1, 1, 0, 0, 0, 32'h0);
    chk("t4_pc_held", if_pc, 32'h10C);
    chk("t4_no_req", imem.req, 1'b0);
    cycle(1, 0, 0, 0, 0, 32'h0);
    chk("t4_resume_req", imem.req, 1'b1);
    chk("t4_resume_addr", imem.addr, 32'h110);

    // Jump in the same cycle as grant: that response is discarded.
    lat_mode = 1;
    cycle(1, 0, 1, 0, 0, 32'h203);
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0);
    chk("t5_valid", if_valid, 1'b0);
    chk("t5_addr", imem.addr, 32'h200);

    // PC wrap at the top of the address space.
    lat_mode = 0;
    cycle(0, 0, 1, 0, 0, 32'hFFFF_FFFF);
    chk("t6_top_addr", imem.addr, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0, 0, 32'h0);
    cycle(1, 0, 0, 0, 0, 32'h0);
    chk("t6_top_pc", if_pc, 32'hFFFF_FFFC);
    chk("t6_wrap_addr", imem.addr, 32'h0);

    // Reset while waiting; the late response lands in the first cycle.
    lat_mode = 2;
    cycle(1, 0, 0, 0, 0, 32'h0);
    do_reset(1'b1);
    cycle(1, 0, 0, 0, 0, 32'h0);
    chk("t6_late_ignored", if_valid, 1'b0);
    chk("t6_restart_req", imem.req, 1'b1);
    chk("t6_restart_addr", imem.addr, 32'h0);

    // Random traffic: grants, latency, stalls, branches and jumps.
    lat_mode = -1;
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(9, 0) < 7, $urandom_range(3, 0) == 0,
            $urandom_range(19, 0) == 0, $urandom_range(5, 0) == 0,
            $urandom_range(1, 0) == 1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
